// File: rtl/seq_detector_pkg.sv
// rtl/seq_detector_pkg.sv - state encoding and pattern constant for the 1011 Moore detector
package seq_detector_pkg;

  localparam logic [4:0] ST_IDLE  = 5'b00001;
  localparam logic [4:0] ST_S1    = 5'b00010;
  localparam logic [4:0] ST_S10   = 5'b00100;
  localparam logic [4:0] ST_S101  = 5'b01000;
  localparam logic [4:0] ST_S1011 = 5'b10000;

  localparam logic [3:0] PATTERN = 4'b1011;

  typedef enum logic [4:0] {
    IDLE  = ST_IDLE,
    S1    = ST_S1,
    S10   = ST_S10,
    S101  = ST_S101,
    S1011 = ST_S1011
  } state_t;

endpackage

// File: rtl/seq_detector_moore.sv
// rtl/seq_detector_moore.sv - overlapping 1011 Moore detector, one bit per clk
// Optional saturating detection counter enabled by SEQ_DET_COUNT_EN.
module seq_detector_moore
  import seq_detector_pkg::*;
`ifdef SEQ_DET_COUNT_EN
#(
  parameter int CNT_W = 8
)
`endif
(
  input  logic             clk,
  input  logic             reset,
  input  logic             seq_in,
`ifdef SEQ_DET_COUNT_EN
  output logic [CNT_W-1:0] detect_count,
`endif
  output logic             detect_out
);

  state_t state;
  state_t next_state;

  // Any encoding outside the five legal one-hot codes falls back to IDLE.
  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:    next_state = seq_in ? S1    : IDLE;
      S1:      next_state = seq_in ? S1    : S10;
      S10:     next_state = seq_in ? S101  : IDLE;
      S101:    next_state = seq_in ? S1011 : S10;
      S1011:   next_state = seq_in ? S1    : S10;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      detect_out <= 1'b0;
`ifdef SEQ_DET_COUNT_EN
      detect_count <= '0;
`endif
    end else begin
      state      <= next_state;
      detect_out <= (next_state == S1011);
`ifdef SEQ_DET_COUNT_EN
      if ((next_state == S1011) && (detect_count != {CNT_W{1'b1}}))
        detect_count <= detect_count + CNT_W'(1);
`endif
    end
  end

endmodule

// File: tb/tb_seq_detector_moore.sv
// tb/tb_seq_detector_moore.sv - randomized self-checking bench for seq_detector_moore
module tb_seq_detector_moore;
  import seq_detector_pkg::*;

  logic clk;
  logic reset;
  logic seq_in;
  logic detect_out;

  int checks;
  int errors;

  int          m_nbits;
  logic [3:0]  m_hist;
  logic        exp_det;
  int          exp_cnt;

`ifdef SEQ_DET_COUNT_EN
  localparam int CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  logic [CNT_W-1:0] detect_count;

  seq_detector_moore #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .seq_in       (seq_in),
    .detect_count (detect_count),
    .detect_out   (detect_out)
  );
`else
  localparam int CNT_MAX = 255;

  seq_detector_moore dut (
    .clk        (clk),
    .reset      (reset),
    .seq_in     (seq_in),
    .detect_out (detect_out)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    m_nbits = 0;
    m_hist  = 4'b0000;
    exp_det = 1'b0;
    exp_cnt = 0;
  endtask

  // Reference: a detection follows any sample whose last four bits since reset spell PATTERN.
  task automatic drive_bit(input logic b);
    seq_in = b;
    @(posedge clk);
    #1;
    m_hist  = {m_hist[2:0], b};
    m_nbits = m_nbits + 1;
    exp_det = (m_nbits >= 4) && (m_hist == PATTERN);
    if (exp_det && exp_cnt < CNT_MAX) exp_cnt = exp_cnt + 1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    seq_in = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    seq_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (detect_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_detect: got %b want 0", detect_out);
    end
    checks++;
    if (dut.state !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got %b want %b", dut.state, IDLE);
    end
`ifdef SEQ_DET_COUNT_EN
    checks++;
    if (detect_count !== '0) begin
      errors++;
      $display("FAIL reset_count: got %0d want 0", detect_count);
    end
`endif
    reset = 1'b0;
    model_clear();
    for (int i = 0; i < 4; i++) begin
      drive_bit(1'b0);
      checks++;
      if (detect_out !== 1'b0 || dut.state !== IDLE) begin
        errors++;
        $display("FAIL idle_after_reset[%0d]: got det=%b state=%b want det=0 state=%b",
                 i, detect_out, dut.state, IDLE);
      end
    end
  endtask

  task automatic run_seq(input string name, input logic [15:0] bits, input int len,
                         output int pulses);
    pulses = 0;
    for (int i = len - 1; i >= 0; i--) begin
      drive_bit(bits[i]);
      if (detect_out === 1'b1) pulses++;
      checks++;
      if (detect_out !== exp_det) begin
        errors++;
        $display("FAIL %s bit%0d: got det=%b want %b", name, len - i, detect_out, exp_det);
      end
`ifdef SEQ_DET_COUNT_EN
      checks++;
      if (detect_count !== CNT_W'(exp_cnt)) begin
        errors++;
        $display("FAIL %s_count bit%0d: got %0d want %0d", name, len - i, detect_count, exp_cnt);
      end
`endif
    end
  endtask

  task automatic test_single();
    int p;
    do_reset();
    run_seq("single", 16'b1011000, 7, p);
    checks++;
    if (p != 1) begin
      errors++;
      $display("FAIL single_pulses: got %0d want 1", p);
    end
  endtask

  task automatic test_back_to_back();
    int p;
    do_reset();
    run_seq("b2b", 16'b1011011, 7, p);
    checks++;
    if (p != 2) begin
      errors++;
      $display("FAIL b2b_pulses: got %0d want 2", p);
    end
  endtask

  task automatic test_self_loop();
    int p;
    do_reset();
    run_seq("selfloop", 16'b111011, 6, p);
    checks++;
    if (p != 1) begin
      errors++;
      $display("FAIL selfloop_pulses: got %0d want 1", p);
    end
    do_reset();
    run_seq("fallback", 16'b1001011, 7, p);
    checks++;
    if (p != 1 || detect_out !== 1'b1) begin
      errors++;
      $display("FAIL fallback_pulses: got %0d last=%b want 1 last=1", p, detect_out);
    end
  endtask

  task automatic test_reset_mid();
    int p;
    do_reset();
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (dut.state !== IDLE || detect_out !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got state=%b det=%b want state=%b det=0",
               dut.state, detect_out, IDLE);
    end
    seq_in = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    run_seq("after_reset", 16'b11, 2, p);
    checks++;
    if (p != 0) begin
      errors++;
      $display("FAIL after_reset_pulses: got %0d want 0", p);
    end
    run_seq("after_reset_full", 16'b011, 3, p);
    checks++;
    if (p != 1) begin
      errors++;
      $display("FAIL after_reset_full_pulses: got %0d want 1", p);
    end
  endtask

`ifdef SEQ_DET_COUNT_EN
  task automatic test_saturate();
    int p;
    do_reset();
    for (int k = 0; k < 5; k++) run_seq("saturate", 16'b1011, 4, p);
    checks++;
    if (detect_count !== CNT_W'(CNT_MAX)) begin
      errors++;
      $display("FAIL saturate_final: got %0d want %0d", detect_count, CNT_MAX);
    end
  endtask
`endif

  task automatic test_random();
    logic b;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        do_reset();
      end
      b = ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0;
      drive_bit(b);
      checks++;
      if (detect_out !== exp_det) begin
        errors++;
        $display("FAIL random_det step%0d: got %b want %b", i, detect_out, exp_det);
      end
`ifdef SEQ_DET_COUNT_EN
      checks++;
      if (detect_count !== CNT_W'(exp_cnt)) begin
        errors++;
        $display("FAIL random_count step%0d: got %0d want %0d", i, detect_count, exp_cnt);
      end
`endif
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    seq_in = 1'b0;
    model_clear();
    test_reset();
    test_single();
    test_back_to_back();
    test_self_loop();
    test_reset_mid();
`ifdef SEQ_DET_COUNT_EN
    test_saturate();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
